// File: rtl/flp_shr_seq_pkg.sv
// Shared state encodings for the shift-right-and-jam sequencer.
package flp_shr_seq_pkg;

  localparam logic [1:0] FLP_ST_IDLE  = 2'd0;
  localparam logic [1:0] FLP_ST_SHIFT = 2'd1;
  localparam logic [1:0] FLP_ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = FLP_ST_IDLE,
    ST_SHIFT = FLP_ST_SHIFT,
    ST_DONE  = FLP_ST_DONE
  } flp_state_e;

endpackage

// File: rtl/flp_shrjam_step.sv
// Combinational small-step right shifter: acc >> amt plus OR of the amt bits lost.
// amt is bounded by STEP, so this stays a narrow mux tree rather than a barrel shifter.
module flp_shrjam_step #(
  parameter int WIDTH = 64,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] shifted,
  output logic             lost
);

  logic [WIDTH-1:0] low_mask;

  always_comb begin
    low_mask = ~({WIDTH{1'b1}} << amt);
    shifted  = acc >> amt;
    lost     = |(acc & low_mask);
  end

endmodule

// File: rtl/flp_shr_seq.sv
// Multi-cycle shift-right-and-jam: result valid floor(min(shamt,WIDTH)/STEP)+1 cycles after accept.
// Result holds in DONE until m_ready; no new operand is taken until the result drains.
module flp_shr_seq
  import flp_shr_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 4,
  parameter int SHW   = 7
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [SHW-1:0]   s_shamt,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_sticky
);

  localparam int AW = $clog2(STEP + 1);

  flp_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic             sticky_q, sticky_d;

  logic             rem_ge_step;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] step_acc;
  logic             step_lost;

  assign rem_ge_step = (rem_q >= SHW'(STEP));
  // Below STEP the remainder fits in the step amount field.
  assign step_amt    = rem_ge_step ? AW'(STEP) : rem_q[AW-1:0];

  flp_shrjam_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .acc     (acc_q),
    .amt     (step_amt),
    .shifted (step_acc),
    .lost    (step_lost)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          acc_d    = s_data;
          rem_d    = (s_shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : s_shamt;
          sticky_d = 1'b0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d    = step_acc;
        sticky_d = sticky_q | step_lost;
        if (rem_ge_step) begin
          rem_d = rem_q - SHW'(STEP);
        end else begin
          rem_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      rem_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
    end
  end

  assign s_ready  = (state_q == ST_IDLE);
  assign m_valid  = (state_q == ST_DONE);
  assign m_data   = {acc_q[WIDTH-1:1], acc_q[0] | sticky_q};
  assign m_sticky = sticky_q;

endmodule
